// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg -- shared types and constants for the MYO SPI slave.
//   state_t    : frame state (IDLE, ACTIVE)
//   WORD_W_DEF : default SPI word width in bits
package myo_spi_pkg;

  localparam int WORD_W_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/myo_sync.sv
// myo_sync -- STAGES-deep flop chain bringing one asynchronous input into
// the clk domain.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   i_d      in  asynchronous input
//   o_q      out synchronized output (resets to RST_VAL)
module myo_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Synchronizer shift chain, preset to the line's idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/myo_spi_slave.sv
// myo_spi_slave -- SPI mode-0 slave with a one-word TX holding register,
// continuous multi-word streaming under one ss_n, underrun and abort flags.
//   clk, reset_n          system clock, async active-low reset
//   sck, mosi, ss_n       SPI master inputs (asynchronous, synchronized here)
//   miso, miso_oe         slave data out and its output enable
//   tx_data/valid/ready   TX holding register write port
//   rx_data/valid         last complete received word, one-clk strobe
//   frame_active          high while a frame is in progress
//   underrun              one-clk pulse when a fallback word is shifted out
//   frame_abort           one-clk pulse when ss_n rises mid-word
// Build option: define MYO_SPI_SLAVE_ECHO_EN to send the most recent
// received word instead of zeros when the holding register is empty.
module myo_spi_slave
  import myo_spi_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic              underrun,
  output logic              frame_abort
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  logic w_sck_s, w_mosi_s, w_ss_n_s;
  logic r_sck_d, r_ss_d;
  logic r_armed;
  logic [AW-1:0] r_arm_cnt;

  state_t            r_state;
  logic              r_active;
  logic [CW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_rx_sr, r_tx_sr, r_rx_data, r_hold;
  logic              r_hold_full, r_rx_valid, r_underrun, r_frame_abort;
  logic              r_uflow_pend;

  logic w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic w_boundary, w_load, w_accept;
  logic [WORD_W-1:0] w_fallback, w_load_word;

  myo_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .i_d(sck), .o_q(w_sck_s));
  myo_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_d(mosi), .o_q(w_mosi_s));
  myo_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .i_d(ss_n), .o_q(w_ss_n_s));

  // Edge registers for the synchronized sck and ss_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_d <= 1'b0;
      r_ss_d  <= 1'b1;
    end else begin
      r_sck_d <= w_sck_s;
      r_ss_d  <= w_ss_n_s;
    end
  end

  // The ss_n synchronizer presets high, so a line still held low when reset
  // releases would look like a fall. Only arm fall detection once ss_n has
  // been seen high for longer than the preset can last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_arm_cnt <= {AW{1'b0}};
    end else if (!r_armed) begin
      if (!w_ss_n_s) begin
        r_arm_cnt <= {AW{1'b0}};
      end else if (r_arm_cnt == AW'(SYNC_STAGES)) begin
        r_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + AW'(1);
      end
    end
  end

  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_ss_fall  = ~w_ss_n_s & r_ss_d & r_armed;
  assign w_ss_rise  = w_ss_n_s & ~r_ss_d;

  assign w_boundary = (r_state == ACTIVE) && (r_bit_cnt == CW'(WORD_W));
  assign w_load     = ~w_ss_rise & (((r_state == IDLE) & w_ss_fall) | w_boundary);
  assign w_accept   = tx_valid & ~r_hold_full;

`ifdef MYO_SPI_SLAVE_ECHO_EN
  // At a word boundary rx_data is being refreshed this very clk, so echo
  // the just-completed word straight from the shift register.
  assign w_fallback = w_boundary ? r_rx_sr : r_rx_data;
`else
  assign w_fallback = {WORD_W{1'b0}};
`endif

  assign w_load_word = r_hold_full ? r_hold : w_fallback;

  // Frame FSM, shift registers, holding register and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_active      <= 1'b0;
      r_bit_cnt     <= {CW{1'b0}};
      r_rx_sr       <= {WORD_W{1'b0}};
      r_tx_sr       <= {WORD_W{1'b0}};
      r_rx_data     <= {WORD_W{1'b0}};
      r_hold        <= {WORD_W{1'b0}};
      r_hold_full   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_uflow_pend  <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_abort <= 1'b0;

      // An accept wins over a same-clk load: the new word stays held.
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      // The underrun is flagged when the fallback word actually starts
      // shifting, so the speculative reload after a frame's last word
      // does not raise it.
      if (w_load) begin
        r_tx_sr      <= w_load_word;
        r_uflow_pend <= ~r_hold_full;
      end

      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state   <= ACTIVE;
            r_active  <= 1'b1;
            r_bit_cnt <= {CW{1'b0}};
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state       <= IDLE;
            r_active      <= 1'b0;
            r_frame_abort <= (r_bit_cnt != {CW{1'b0}});
            r_bit_cnt     <= {CW{1'b0}};
            r_rx_sr       <= {WORD_W{1'b0}};
            r_tx_sr       <= {WORD_W{1'b0}};
            r_uflow_pend  <= 1'b0;
          end else if (w_boundary) begin
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
            r_bit_cnt  <= {CW{1'b0}};
          end else if (w_sck_rise) begin
            r_rx_sr   <= {r_rx_sr[WORD_W-2:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + CW'(1);
            if (r_uflow_pend) begin
              r_underrun   <= 1'b1;
              r_uflow_pend <= 1'b0;
            end
          end else if (w_sck_fall && (r_bit_cnt != {CW{1'b0}})) begin
            // The fall after a word's last bit is skipped: the freshly
            // reloaded MSB is already on miso.
            r_tx_sr <= {r_tx_sr[WORD_W-2:0], 1'b0};
          end
        end
        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign miso         = r_tx_sr[WORD_W-1];
  assign miso_oe      = r_active;
  assign frame_active = r_active;
  assign tx_ready     = ~r_hold_full;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign underrun     = r_underrun;
  assign frame_abort  = r_frame_abort;

endmodule

// File: tb/tb_myo_spi_slave.sv
// tb_myo_spi_slave -- directed self-checking bench for myo_spi_slave
// (WORD_W=16, SYNC_STAGES=2). Honors MYO_SPI_SLAVE_ECHO_EN for the
// underrun fallback expectations.
module tb_myo_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso, miso_oe, tx_ready, rx_valid, frame_active, underrun, frame_abort;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic [15:0] rx_data;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_abt = 0;
  logic [15:0] last_rx = 16'h0000;

  always #5 clk = ~clk;

  myo_spi_slave #(.WORD_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_active(frame_active), .underrun(underrun), .frame_abort(frame_abort));

  // Pulse counters and capture of the word delivered with rx_valid.
  always @(posedge clk) begin
    if (rx_valid) begin
      n_rxv   <= n_rxv + 1;
      last_rx <= rx_data;
    end
    if (underrun) n_und <= n_und + 1;
    if (frame_abort) n_abt <= n_abt + 1;
  end

  task automatic tx_push(input logic [15:0] d);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_push_wait: tx_ready=%b required 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_begin;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end;
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Shift nbits MSB-first. With arm set, tx_valid is raised exactly on the
  // clk in which the slave performs the word-boundary reload.
  task automatic spi_xfer(input logic [15:0] mo, input int nbits, input bit arm,
                          input logic [15:0] pd, output logic [15:0] mi);
    mi = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[15-i];
      repeat (5) @(negedge clk);
      sck = 1'b1;
      mi[15-i] = miso;
      if (arm && i == nbits - 1) begin
        repeat (3) @(negedge clk);
        tx_data  = pd;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      sck = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    obs = {miso, miso_oe, frame_active, tx_ready, rx_valid, underrun, frame_abort};
    checks++;
    if (obs !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0001000", obs);
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx_data: got %h required 0000", rx_data);
    end
  endtask

  task automatic test_single;
    logic [15:0] m;
    int r0, u0;
    r0 = n_rxv; u0 = n_und;
    tx_push(16'hA55A);
    spi_begin();
    checks++;
    if (miso_oe !== 1'b1 || frame_active !== 1'b1) begin
      errors++;
      $display("FAIL single_active: oe=%b active=%b required 1 1", miso_oe, frame_active);
    end
    spi_xfer(16'h1234, 16, 1'b0, 16'h0000, m);
    spi_end();
    checks++;
    if (m !== 16'hA55A) begin errors++; $display("FAIL single_miso: got %h required a55a", m); end
    checks++;
    if (n_rxv - r0 !== 1) begin errors++; $display("FAIL single_rxv: got %0d required 1", n_rxv - r0); end
    checks++;
    if (last_rx !== 16'h1234) begin errors++; $display("FAIL single_rx: got %h required 1234", last_rx); end
    checks++;
    if (n_und - u0 !== 0) begin errors++; $display("FAIL single_und: got %0d required 0", n_und - u0); end
    checks++;
    if (miso_oe !== 1'b0 || miso !== 1'b0 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: oe=%b miso=%b active=%b required 0 0 0", miso_oe, miso, frame_active);
    end
  endtask

  task automatic test_burst;
    logic [15:0] m1, m2, m3;
    int r0, u0;
    r0 = n_rxv; u0 = n_und;
    tx_push(16'h0001);
    spi_begin();
    tx_push(16'h0002);
    spi_xfer(16'hC001, 16, 1'b0, 16'h0000, m1);
    tx_push(16'h0003);
    spi_xfer(16'hC002, 16, 1'b0, 16'h0000, m2);
    spi_xfer(16'hC003, 16, 1'b0, 16'h0000, m3);
    spi_end();
    checks++;
    if (m1 !== 16'h0001) begin errors++; $display("FAIL burst_w1: got %h required 0001", m1); end
    checks++;
    if (m2 !== 16'h0002) begin errors++; $display("FAIL burst_w2: got %h required 0002", m2); end
    checks++;
    if (m3 !== 16'h0003) begin errors++; $display("FAIL burst_w3: got %h required 0003", m3); end
    checks++;
    if (n_rxv - r0 !== 3) begin errors++; $display("FAIL burst_rxv: got %0d required 3", n_rxv - r0); end
    checks++;
    if (last_rx !== 16'hC003) begin errors++; $display("FAIL burst_rx: got %h required c003", last_rx); end
    checks++;
    if (n_und - u0 !== 0) begin errors++; $display("FAIL burst_und: got %0d required 0", n_und - u0); end
  endtask

  task automatic test_underrun;
    logic [15:0] m1, m2, exp2;
    int r0, u0;
`ifdef MYO_SPI_SLAVE_ECHO_EN
    exp2 = 16'h5A5A;
`else
    exp2 = 16'h0000;
`endif
    r0 = n_rxv; u0 = n_und;
    tx_push(16'hBEEF);
    spi_begin();
    spi_xfer(16'h5A5A, 16, 1'b0, 16'h0000, m1);
    spi_xfer(16'h0F0F, 16, 1'b0, 16'h0000, m2);
    spi_end();
    checks++;
    if (m1 !== 16'hBEEF) begin errors++; $display("FAIL under_w1: got %h required beef", m1); end
    checks++;
    if (m2 !== exp2) begin errors++; $display("FAIL under_w2: got %h required %h", m2, exp2); end
    checks++;
    if (n_und - u0 !== 1) begin errors++; $display("FAIL under_cnt: got %0d required 1", n_und - u0); end
    checks++;
    if (n_rxv - r0 !== 2 || last_rx !== 16'h0F0F) begin
      errors++;
      $display("FAIL under_rx: rxv=%0d rx=%h required 2 0f0f", n_rxv - r0, last_rx);
    end
  endtask

  task automatic test_abort;
    logic [15:0] m, expw;
    int r0, a0;
    r0 = n_rxv; a0 = n_abt;
    expw = 16'h3C3C;
    tx_push(16'h3C3C);
    spi_begin();
    tx_push(16'h7E7E);
    spi_xfer(16'hA5A5, 7, 1'b0, 16'h0000, m);
    spi_end();
    checks++;
    if (n_abt - a0 !== 1) begin errors++; $display("FAIL abort_cnt: got %0d required 1", n_abt - a0); end
    checks++;
    if (n_rxv - r0 !== 0) begin errors++; $display("FAIL abort_rxv: got %0d required 0", n_rxv - r0); end
    checks++;
    if (m[15:9] !== expw[15:9]) begin errors++; $display("FAIL abort_bits: got %b required %b", m[15:9], expw[15:9]); end
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_hold: tx_ready=%b required 0", tx_ready); end
    spi_begin();
    spi_xfer(16'h0F0F, 16, 1'b0, 16'h0000, m);
    spi_end();
    checks++;
    if (m !== 16'h7E7E) begin errors++; $display("FAIL abort_next_miso: got %h required 7e7e", m); end
    checks++;
    if (n_rxv - r0 !== 1 || last_rx !== 16'h0F0F || n_abt - a0 !== 1) begin
      errors++;
      $display("FAIL abort_next_rx: rxv=%0d rx=%h abt=%0d required 1 0f0f 1", n_rxv - r0, last_rx, n_abt - a0);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] m;
    int r0, a0, u0;
    r0 = n_rxv; a0 = n_abt; u0 = n_und;
    tx_push(16'h1357);
    spi_begin();
    spi_xfer(16'hFFFF, 9, 1'b0, 16'h0000, m);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (frame_active !== 1'b0 || miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_restart: active=%b oe=%b required 0 0", frame_active, miso_oe);
    end
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_rxv - r0 !== 0 || n_abt - a0 !== 0 || n_und - u0 !== 0) begin
      errors++;
      $display("FAIL rst_pulses: rxv=%0d abt=%0d und=%0d required 0 0 0", n_rxv - r0, n_abt - a0, n_und - u0);
    end
    tx_push(16'h2468);
    spi_begin();
    spi_xfer(16'h9999, 16, 1'b0, 16'h0000, m);
    spi_end();
    checks++;
    if (m !== 16'h2468) begin errors++; $display("FAIL rst_next_miso: got %h required 2468", m); end
    checks++;
    if (n_rxv - r0 !== 1 || last_rx !== 16'h9999) begin
      errors++;
      $display("FAIL rst_next_rx: rxv=%0d rx=%h required 1 9999", n_rxv - r0, last_rx);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] m1, m2, m3, exp2;
    int r0, u0;
`ifdef MYO_SPI_SLAVE_ECHO_EN
    exp2 = 16'h8001;
`else
    exp2 = 16'h0000;
`endif
    r0 = n_rxv; u0 = n_und;
    tx_push(16'h1111);
    spi_begin();
    spi_xfer(16'h8001, 16, 1'b1, 16'h2222, m1);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_held: tx_ready=%b required 0", tx_ready); end
    spi_xfer(16'h4002, 16, 1'b0, 16'h0000, m2);
    spi_xfer(16'h2004, 16, 1'b0, 16'h0000, m3);
    spi_end();
    checks++;
    if (m1 !== 16'h1111) begin errors++; $display("FAIL b2b_w1: got %h required 1111", m1); end
    checks++;
    if (m2 !== exp2) begin errors++; $display("FAIL b2b_w2: got %h required %h", m2, exp2); end
    checks++;
    if (m3 !== 16'h2222) begin errors++; $display("FAIL b2b_w3: got %h required 2222", m3); end
    checks++;
    if (n_und - u0 !== 1 || n_rxv - r0 !== 3) begin
      errors++;
      $display("FAIL b2b_counts: und=%0d rxv=%0d required 1 3", n_und - u0, n_rxv - r0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    test_single();
    test_burst();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
